// File: rtl/ysyx_00000000_axi_pkg.sv
// Shared types and constants for the ysyx_00000000 AXI read path.
package ysyx_00000000_axi_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [3:0] ARID_IFU    = 4'h0;
  localparam logic [3:0] ARID_LSU    = 4'h1;

endpackage

// File: rtl/ysyx_00000000_rr_pick.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is chosen; with a single requester that requester is chosen.
module ysyx_00000000_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  // Pick the winner from the current requests and the previous winner.
  always_comb begin
    any = |req;
    if (&req) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/ysyx_00000000_rd_arbiter.sv
// 2:1 read-channel arbiter: IFU (port 0) and LSU (port 1) share one
// single-beat AXI4 read master, one transaction in flight at a time.
// Optional feature: define ARB_TIMEOUT_EN to bound the R-channel wait and
// answer the requester with DECERR when the slave stays silent.
module ysyx_00000000_rd_arbiter
  import ysyx_00000000_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          RESET_LAST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  // IFU port
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [2:0]        m0_arsize,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  // LSU port
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [2:0]        m1_arsize,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  // Downstream AR
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [2:0]        s_arsize,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [1:0]        s_arburst,
  // Downstream R
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("ysyx_00000000_rd_arbiter: TIMEOUT must be within 1..255");
  end

  arb_state_e        state_q, state_d;
  logic              last_q;
  logic              grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              orphan_q;
  logic              timeout_hit;

  logic pick_grant, pick_any;
  logic idle_open, ar_fire, r_fire, resp_fire;
  logic [1:0] rresp_chk;

  ysyx_00000000_rr_pick u_pick (
    .req   ({m1_arvalid, m0_arvalid}),
    .last  (last_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Requests are only taken in IDLE, never while an abandoned response is
  // still owed, and never while reset is held (arready is combinational).
  assign idle_open  = (state_q == IDLE) && pick_any && !orphan_q && reset;
  assign m0_arready = idle_open && !pick_grant;
  assign m1_arready = idle_open &&  pick_grant;
  assign ar_fire    = (m0_arvalid && m0_arready) || (m1_arvalid && m1_arready);

  assign s_arvalid  = (state_q == ADDR);
  assign s_araddr   = addr_q;
  assign s_arsize   = size_q;
  assign s_arid     = grant_q ? ARID_LSU : ARID_IFU;
  assign s_arlen    = 8'h00;
  assign s_arburst  = BURST_INCR;

  assign s_rready   = (state_q == DATA) || orphan_q;
  assign r_fire     = (state_q == DATA) && s_rvalid;
  // A beat for the wrong ID or without RLAST is a protocol error downstream.
  assign rresp_chk  = ((s_rid == s_arid) && s_rlast) ? s_rresp : RESP_SLVERR;

  assign m0_rvalid  = (state_q == RESP) && !grant_q;
  assign m1_rvalid  = (state_q == RESP) &&  grant_q;
  assign m0_rdata   = rdata_q;
  assign m1_rdata   = rdata_q;
  assign m0_rresp   = rresp_q;
  assign m1_rresp   = rresp_q;
  assign resp_fire  = (state_q == RESP) && (grant_q ? m1_rready : m0_rready);

  // Next-state logic for the four-phase transaction.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ar_fire)                 state_d = ADDR;
      ADDR:    if (s_arready)               state_d = DATA;
      DATA:    if (s_rvalid || timeout_hit) state_d = RESP;
      RESP:    if (resp_fire)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // FSM state register and round-robin history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= RESET_LAST;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (resp_fire) last_q <= grant_q;
    end
  end

  // Per-transaction latches: request fields on accept, response on R beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: these are a handful of flops, not a storage array, so they are
      // reset to keep the response outputs defined from the first cycle.
      grant_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        grant_q <= pick_grant;
        addr_q  <= pick_grant ? m1_araddr : m0_araddr;
        size_q  <= pick_grant ? m1_arsize : m0_arsize;
      end
      if (r_fire) begin
        rdata_q <= s_rdata;
        rresp_q <= rresp_chk;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        rresp_q <= RESP_DECERR;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q;

  assign timeout_hit = (state_q == DATA) && !s_rvalid && (wait_cnt_q == TimeoutLast);

  // Count silent DATA cycles; remember that the slave still owes one beat
  // after a timeout so that beat is swallowed instead of misrouted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      if ((state_q == ADDR) && s_arready) begin
        wait_cnt_q <= '0;
      end else if ((state_q == DATA) && !s_rvalid) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (timeout_hit) begin
        orphan_q <= 1'b1;
      end else if (orphan_q && s_rvalid) begin
        orphan_q <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign orphan_q    = 1'b0;
`endif

endmodule
